// File: rtl/logic_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_mc
//  Purpose  : Multicycle bitwise logic unit. Applies one of eight bitwise ops
//             to two WIDTH-bit operands, CHUNK bits per clock (LSB chunk
//             first), and accumulates a popcount and result-zero flag.
//  Ports    : clock, reset (async, active-high)
//             in_valid / in_ready          - request handshake
//             op, data_a, data_b           - opcode and operands
//             out_valid / out_ready        - result handshake
//             result, result_zero, popcount- outputs (valid with out_valid)
//             busy                         - operation in flight
//  Revision : 1.0 - initial release
// ============================================================================
module logic_unit_mc #(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int PCW   = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_zero,
    output logic [PCW-1:0]   popcount,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("logic_unit_mc: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [PCW-1:0]     r_popcount;
    logic               r_result_zero;
    logic               r_out_valid;
    logic               r_busy;

    int                 w_base;
    logic [CHUNK-1:0]   w_ca;
    logic [CHUNK-1:0]   w_cb;
    logic [CHUNK-1:0]   w_cres;
    logic [PCW-1:0]     w_pc_next;

    function automatic logic [PCW-1:0] count_ones(input logic [CHUNK-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    // Operand slice selected by the chunk counter.
    assign w_base = int'(r_cnt) * CHUNK;
    assign w_ca   = r_a[w_base +: CHUNK];
    assign w_cb   = r_b[w_base +: CHUNK];

    always_comb begin
        w_cres = '0;
        case (r_op)
            3'b000:  w_cres = w_ca & w_cb;
            3'b001:  w_cres = w_ca | w_cb;
            3'b010:  w_cres = w_ca ^ w_cb;
            3'b011:  w_cres = ~(w_ca | w_cb);
            3'b100:  w_cres = w_ca & ~w_cb;
            3'b101:  w_cres = ~(w_ca & w_cb);
            3'b110:  w_cres = ~(w_ca ^ w_cb);
            default: w_cres = w_ca;
        endcase
    end

    // Cannot overflow: total never exceeds WIDTH, which fits in PCW bits.
    assign w_pc_next = r_popcount + count_ones(w_cres);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_popcount    <= '0;
            r_result_zero <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op          <= op;
                        r_a           <= data_a;
                        r_b           <= data_b;
                        r_cnt         <= '0;
                        r_result      <= '0;
                        r_popcount    <= '0;
                        r_result_zero <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_result[w_base +: CHUNK] <= w_cres;
                    r_popcount    <= w_pc_next;
                    r_result_zero <= (w_pc_next == '0);
                    if (r_cnt == C_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result is held; no new op is taken on the release edge.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the unit reports not-ready while held in reset and
    // ready as soon as reset is released.
    assign in_ready    = (r_state == S_IDLE) && !reset;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign result      = r_result;
    assign popcount    = r_popcount;
    assign result_zero = r_result_zero;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_mc
//  Purpose  : Directed self-checking bench for logic_unit_mc. Three instances:
//             default (32/8), single-chunk (32/32) and narrow (16/4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_mc;

    logic clk;
    logic rst;

    // Instance 0: WIDTH=32, CHUNK=8
    logic        iv0, ir0, ov0, or0, rz0, bz0;
    logic [2:0]  op0;
    logic [31:0] a0, b0, res0;
    logic [5:0]  pc0;

    // Instance 1: WIDTH=32, CHUNK=32
    logic        iv1, ir1, ov1, or1, rz1, bz1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, res1;
    logic [5:0]  pc1;

    // Instance 2: WIDTH=16, CHUNK=4
    logic        iv2, ir2, ov2, or2, rz2, bz2;
    logic [2:0]  op2;
    logic [15:0] a2, b2, res2;
    logic [4:0]  pc2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sv_res;
    logic [5:0]  sv_pc;
    int          lat;

    logic [2:0]  sw_op  [8];
    logic [31:0] sw_res [8];
    logic [5:0]  sw_pc  [8];

    logic_unit_mc #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clock(clk), .reset(rst), .in_valid(iv0), .in_ready(ir0), .op(op0),
        .data_a(a0), .data_b(b0), .out_valid(ov0), .out_ready(or0),
        .result(res0), .result_zero(rz0), .popcount(pc0), .busy(bz0));

    logic_unit_mc #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clock(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .op(op1),
        .data_a(a1), .data_b(b1), .out_valid(ov1), .out_ready(or1),
        .result(res1), .result_zero(rz1), .popcount(pc1), .busy(bz1));

    logic_unit_mc #(.WIDTH(16), .CHUNK(4)) u_dut2 (
        .clock(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .op(op2),
        .data_a(a2), .data_b(b2), .out_valid(ov2), .out_ready(or2),
        .result(res2), .result_zero(rz2), .popcount(pc2), .busy(bz2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one op on instance 0, then wait (bounded) for out_valid.
    task automatic issue0(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op0 = o; a0 = a; b0 = b; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0; op0 = 3'b000; a0 = '0; b0 = '0;
        check("in_ready_after_accept", 64'(ir0), 64'd0);
        check("busy_after_accept", 64'(bz0), 64'd1);
        lat = 0;
        while (ov0 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release0();
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
        check("in_ready_after_release", 64'(ir0), 64'd1);
        check("out_valid_after_release", 64'(ov0), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        iv0 = 0; or0 = 0; op0 = 0; a0 = 0; b0 = 0;
        iv1 = 0; or1 = 0; op1 = 0; a1 = 0; b1 = 0;
        iv2 = 0; or2 = 0; op2 = 0; a2 = 0; b2 = 0;
        sw_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        sw_res = '{32'h0000_00FF, 32'h00FF_FFFF, 32'h00FF_FF00, 32'hFF00_0000,
                   32'h0000_FF00, 32'hFFFF_FF00, 32'hFF00_00FF, 32'h0000_FFFF};
        sw_pc  = '{6'd8, 6'd24, 6'd16, 6'd8, 6'd8, 6'd24, 6'd16, 6'd16};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(ir0), 64'd0);
        check("rst_out_valid", 64'(ov0), 64'd0);
        check("rst_busy", 64'(bz0), 64'd0);
        check("rst_result", 64'(res0), 64'd0);
        check("rst_popcount", 64'(pc0), 64'd0);
        check("rst_result_zero", 64'(rz0), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(ir0), 64'd1);

        // AND
        issue0(3'b000, 32'hF0F0_1234, 32'hFF00_FFFF);
        check("and_latency", 64'(lat), 64'd4);
        check("and_result", 64'(res0), 64'hF000_1234);
        check("and_popcount", 64'(pc0), 64'd9);
        check("and_zero", 64'(rz0), 64'd0);
        release0();

        // XOR to zero
        issue0(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("xor_latency", 64'(lat), 64'd4);
        check("xor_result", 64'(res0), 64'd0);
        check("xor_popcount", 64'(pc0), 64'd0);
        check("xor_zero", 64'(rz0), 64'd1);
        release0();

        // NOR all ones, full popcount
        issue0(3'b011, 32'h0, 32'h0);
        check("nor_result", 64'(res0), 64'hFFFF_FFFF);
        check("nor_popcount", 64'(pc0), 64'd32);
        check("nor_zero", 64'(rz0), 64'd0);
        release0();

        // Sweep all ops
        for (int i = 0; i < 8; i++) begin
            issue0(sw_op[i], 32'h0000_FFFF, 32'h00FF_00FF);
            check($sformatf("sweep%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("sweep%0d_result", i), 64'(res0), 64'(sw_res[i]));
            check($sformatf("sweep%0d_popcount", i), 64'(pc0), 64'(sw_pc[i]));
            release0();
        end

        // Backpressure in DONE
        issue0(3'b001, 32'h1234_0000, 32'h0000_5678);
        sv_res = 32'h1234_5678;
        sv_pc  = 6'd13;
        for (int i = 0; i < 10; i++) begin
            op0 = 3'b111; a0 = 32'hAAAA_0000 + 32'(i); b0 = 32'h5555_5555; iv0 = (i % 2) == 0;
            @(negedge clk);
            check("bp_out_valid", 64'(ov0), 64'd1);
            check("bp_in_ready", 64'(ir0), 64'd0);
            check("bp_result", 64'(res0), 64'(sv_res));
            check("bp_popcount", 64'(pc0), 64'(sv_pc));
        end
        iv0 = 1'b0;
        release0();
        @(negedge clk);
        check("bp_idle_hold", 64'(bz0), 64'd0);
        issue0(3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F);
        check("post_bp_result", 64'(res0), 64'hF0F0_0000);
        check("post_bp_popcount", 64'(pc0), 64'd8);
        release0();

        // Reset mid-BUSY
        @(negedge clk);
        op0 = 3'b110; a0 = 32'h1111_1111; b0 = 32'h2222_2222; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(ov0), 64'd0);
        check("midrst_busy", 64'(bz0), 64'd0);
        check("midrst_result", 64'(res0), 64'd0);
        check("midrst_popcount", 64'(pc0), 64'd0);
        check("midrst_in_ready", 64'(ir0), 64'd0);
        @(negedge clk);
        check("midrst_in_ready_hold", 64'(ir0), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_release", 64'(ir0), 64'd1);
        issue0(3'b001, 32'h1, 32'h2);
        check("postrst_latency", 64'(lat), 64'd4);
        check("postrst_result", 64'(res0), 64'h3);
        check("postrst_popcount", 64'(pc0), 64'd2);
        release0();

        // Single-chunk instance: ANDN
        @(negedge clk);
        op1 = 3'b100; a1 = 32'hFFFF_FFFF; b1 = 32'h0F0F_0F0F; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        check("n1_busy", 64'(bz1), 64'd1);
        lat = 0;
        while (ov1 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n1_latency", 64'(lat), 64'd1);
        check("n1_result", 64'(res1), 64'hF0F0_F0F0);
        check("n1_popcount", 64'(pc1), 64'd16);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        check("n1_in_ready", 64'(ir1), 64'd1);

        // Narrow instance: PASS A
        op2 = 3'b111; a2 = 16'h8001; b2 = 16'hFFFF; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        lat = 0;
        while (ov2 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w16_latency", 64'(lat), 64'd4);
        check("w16_result", 64'(res2), 64'h8001);
        check("w16_popcount", 64'(pc2), 64'd2);
        check("w16_zero", 64'(rz2), 64'd0);
        or2 = 1'b1;
        @(negedge clk);
        or2 = 1'b0;
        check("w16_in_ready", 64'(ir2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
